// File: rtl/byte_window_fifo.sv
// Byte-granular width converter: IN_BYTES-wide beats in, sliding WIN_BYTES window out, advancing STRIDE per pop.
// Latency: a pushed byte is readable right after its write edge (one extra cycle with BYTE_WINDOW_FIFO_OUT_REG_EN).
// Backpressure: in_ready only when a full beat fits in registered count; out_data/out_valid hold while out_ready=0.
module byte_window_fifo #(
    parameter int BYTE_W      = 8,
    parameter int IN_BYTES    = 8,
    parameter int WIN_BYTES   = 3,
    parameter int STRIDE      = 1,
    parameter int DEPTH_BYTES = 16,
    localparam int CW         = $clog2(DEPTH_BYTES + 1),
    localparam int PW         = $clog2(DEPTH_BYTES)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [IN_BYTES*BYTE_W-1:0]    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIN_BYTES*BYTE_W-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CW-1:0]                 count
);

    logic [BYTE_W-1:0]            mem [DEPTH_BYTES];
    logic [PW-1:0]                wp;
    logic [PW-1:0]                rp;
    logic [WIN_BYTES*BYTE_W-1:0]  rd_win;
    logic                         have_win;
    logic                         push;
    logic                         st_pop;

    // Offsets never exceed DEPTH_BYTES, so one conditional subtract wraps correctly.
    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= DEPTH_BYTES) s = s - DEPTH_BYTES;
        return PW'(s);
    endfunction

    assign in_ready = (count <= CW'(DEPTH_BYTES - IN_BYTES));
    assign have_win = (count >= CW'(WIN_BYTES));
    assign push     = in_valid & in_ready;

    always_comb begin
        rd_win = '0;
        for (int k = 0; k < WIN_BYTES; k++) begin
            rd_win[k*BYTE_W +: BYTE_W] = mem[wrap(rp, k)];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                for (int k = 0; k < IN_BYTES; k++) begin
                    mem[wrap(wp, k)] <= in_data[k*BYTE_W +: BYTE_W];
                end
                wp <= wrap(wp, IN_BYTES);
            end
            if (st_pop) rp <= wrap(rp, STRIDE);
            count <= count + (push ? CW'(IN_BYTES) : CW'(0)) - (st_pop ? CW'(STRIDE) : CW'(0));
        end
    end

`ifdef BYTE_WINDOW_FIFO_OUT_REG_EN
    logic                         ore_vld;
    logic [WIN_BYTES*BYTE_W-1:0]  ore_dat;

    // The register refills from the store whenever it is empty or draining this cycle.
    assign st_pop = have_win & (~ore_vld | out_ready);

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            ore_vld <= 1'b0;
            ore_dat <= '0;
        end else if (st_pop) begin
            ore_vld <= 1'b1;
            ore_dat <= rd_win;
        end else if (out_ready) begin
            ore_vld <= 1'b0;
        end
    end

    assign out_valid = ore_vld;
    assign out_data  = ore_dat;
`else
    assign st_pop    = have_win & out_ready;
    assign out_valid = have_win;
    assign out_data  = rd_win;
`endif

endmodule
